// File: rtl/ffd_posedge_pkg.sv
// rtl/ffd_posedge_pkg.sv - shared defaults for the ffd_posedge storage element
//
// Purpose : holds the default geometry for the D flip-flop and its
//           companion interface, so both agree on width without
//           repeating literals.
// Ports   : none (package)
package ffd_posedge_pkg;

    // Default storage width; wider registers override WIDTH on the instance.
    localparam int FFD_DEFAULT_WIDTH = 1;

endpackage : ffd_posedge_pkg

// File: rtl/ffd_posedge_if.sv
// rtl/ffd_posedge_if.sv - signal bundle wrapping the flip-flop data path
//
// Purpose : groups the data input, reset and registered output of one
//           ffd_posedge instance so a driver and the flop can be wired
//           as a unit.
// Signals : data - D input, driven by the master
//           rst  - synchronous active-high reset, driven by the master
//           q    - registered output, driven by the flop (slave)
interface ffd_posedge_if
    import ffd_posedge_pkg::*;
#(
    parameter int WIDTH = FFD_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] data;
    logic             rst;
    logic [WIDTH-1:0] q;

    // Driver side: supplies data and reset, observes the stored value.
    modport master (
        output data,
        output rst,
        input  q
    );

    // Flop side: consumes data and reset, produces the stored value.
    modport slave (
        input  data,
        input  rst,
        output q
    );

endinterface : ffd_posedge_if

// File: rtl/ffd_posedge.sv
// rtl/ffd_posedge.sv - rising-edge D flip-flop with synchronous active-high reset
//
// Purpose : basic storage element. Q loads data on every rising clk edge;
//           on an edge where rst is high Q loads RESET_VALUE instead.
//           Wider registers are made by overriding WIDTH.
// Ports   : Q    out  WIDTH  registered output
//           clk  in   1      clock, rising edge only
//           data in   WIDTH  D input, sampled on the rising edge
//           rst  in   1      synchronous reset, active-high
// Positional order (Q, clk, data, rst) is kept so older benches that
// connect only the first three ports still bind correctly.
module ffd_posedge
    import ffd_posedge_pkg::*;
#(
    parameter int               WIDTH       = FFD_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output reg   [WIDTH-1:0] Q,
    input  logic             clk,
    input  logic [WIDTH-1:0] data,
    input  logic             rst
);

    // An X/Z or unconnected rst takes the else branch, so the flop keeps
    // loading data unless reset is a solid 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= data;
        end
    end

endmodule : ffd_posedge

// File: tb/tb_ffd_posedge.sv
// tb/tb_ffd_posedge.sv - scoreboard bench for ffd_posedge (1-bit and 8-bit)
module tb_ffd_posedge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ffd_posedge_if #(.WIDTH(1)) n_if ();
    ffd_posedge_if #(.WIDTH(8)) w_if ();

    ffd_posedge #(.WIDTH(1), .RESET_VALUE(1'b0)) u_narrow (
        .Q    (n_if.q),
        .clk  (clk),
        .data (n_if.data),
        .rst  (n_if.rst)
    );

    ffd_posedge #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_wide (
        .Q    (w_if.q),
        .clk  (clk),
        .data (w_if.data),
        .rst  (w_if.rst)
    );

    int total = 0;
    int bad   = 0;

    logic       sb_n[$];
    logic [7:0] sb_w[$];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive both flops, record what each must show after the edge,
    // then compare one time unit past the edge.
    task automatic edge_step(input string tag, input logic nd, input logic nr,
                             input logic [7:0] wd, input logic wr);
        logic       en;
        logic [7:0] ew;
        n_if.data = nd;
        n_if.rst  = nr;
        w_if.data = wd;
        w_if.rst  = wr;
        sb_n.push_back(nr ? 1'b0 : nd);
        sb_w.push_back(wr ? 8'hA5 : wd);
        @(posedge clk);
        #1;
        if (sb_n.size() == 0 || sb_w.size() == 0) begin
            check_val({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            en = sb_n.pop_front();
            ew = sb_w.pop_front();
            check_val({tag, "_n"}, {7'd0, n_if.q}, {7'd0, en});
            check_val({tag, "_w"}, w_if.q, ew);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       held_n;
        logic [7:0] held_w;

        // Power-up: first edge with data=0, no reset.
        n_if.data = 1'b0;
        n_if.rst  = 1'b0;
        w_if.data = 8'h00;
        w_if.rst  = 1'b0;
        edge_step("powerup", 1'b0, 1'b0, 8'h00, 1'b0);

        // Free-running random data, reset low.
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            edge_step("rand", r[0], 1'b0, r, 1'b0);
        end

        // Reset held for two edges with data=1, then released.
        edge_step("rst1", 1'b1, 1'b1, 8'hFF, 1'b1);
        edge_step("rst2", 1'b1, 1'b1, 8'hFF, 1'b1);
        edge_step("release", 1'b1, 1'b0, 8'h5A, 1'b0);

        // Data toggles between edges: Q must hold.
        edge_step("pre_toggle", 1'b0, 1'b0, 8'h11, 1'b0);
        n_if.data = 1'b1; w_if.data = 8'h22; #2;
        check_val("hold_a_n", {7'd0, n_if.q}, 8'h00);
        check_val("hold_a_w", w_if.q, 8'h11);
        n_if.data = 1'b0; w_if.data = 8'h33; #2;
        check_val("hold_b_n", {7'd0, n_if.q}, 8'h00);
        check_val("hold_b_w", w_if.q, 8'h11);
        edge_step("post_toggle", 1'b1, 1'b0, 8'h44, 1'b0);

        // Reset raised mid-cycle: no change until the next edge.
        edge_step("pre_midrst", 1'b1, 1'b0, 8'h3C, 1'b0);
        held_n = n_if.q;
        held_w = w_if.q;
        n_if.rst = 1'b1; w_if.rst = 1'b1; #2;
        check_val("midrst_hold_n", {7'd0, n_if.q}, {7'd0, 1'b1});
        check_val("midrst_hold_w", w_if.q, 8'h3C);
        if (held_n !== 1'b1 || held_w !== 8'h3C)
            check_val("midrst_setup", held_w, 8'h3C);
        edge_step("midrst_edge", 1'b1, 1'b1, 8'h77, 1'b1);

        // Wide register follows data with one-edge latency after reset.
        edge_step("w_3c", 1'b0, 1'b0, 8'h3C, 1'b0);
        edge_step("w_ff", 1'b1, 1'b0, 8'hFF, 1'b0);
        edge_step("w_rst", 1'b1, 1'b1, 8'h00, 1'b1);
        edge_step("w_00", 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-stream on random data.
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            edge_step("mix", r[0], r[1] & r[2], r, r[3]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ffd_posedge
